// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl: serial unsigned magnitude comparator.
// Two WIDTH-bit operands are compared one 2-bit digit per clock, MSB digit
// first, through a single 2-bit compare slice. The result is registered and
// flagged with a one-cycle done pulse.
// Optional macro EARLY_EXIT_EN: leave RUN on the first differing digit
// instead of always running all DIGITS cycles (results are identical).
module serial_mag_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             aeb,
    output logic             agb,
    output logic             alb
);

    localparam int DIGITS = WIDTH / 2;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sha, shb;
    logic [IW-1:0]    idx;
    logic             dec_gt, dec_lt;

    logic [1:0]       da, db;
    logic             decided;
    logic             gt_n, lt_n;
    logic             last;
    logic             run_exit;

    // 2-bit compare slice on the current top digits plus the sticky decision update
    always_comb begin
        da       = sha[WIDTH-1 -: 2];
        db       = shb[WIDTH-1 -: 2];
        decided  = dec_gt | dec_lt;
        gt_n     = dec_gt | (!decided & (da > db));
        lt_n     = dec_lt | (!decided & (da < db));
        last     = (idx == '0);
`ifdef EARLY_EXIT_EN
        run_exit = last | (!decided & (da != db));
`else
        run_exit = last;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (run_exit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand capture, digit stepping, decision accumulation and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha    <= '0;
            shb    <= '0;
            idx    <= '0;
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
            aeb    <= 1'b0;
            agb    <= 1'b0;
            alb    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sha    <= a;
                        shb    <= b;
                        idx    <= IW'(DIGITS - 1);
                        dec_gt <= 1'b0;
                        dec_lt <= 1'b0;
                    end
                end
                RUN: begin
                    sha    <= sha << 2;
                    shb    <= shb << 2;
                    idx    <= idx - 1'b1;
                    dec_gt <= gt_n;
                    dec_lt <= lt_n;
                    if (run_exit) begin
                        aeb <= !(gt_n | lt_n);
                        agb <= gt_n;
                        alb <= lt_n;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_mag_comp_ctrl.md
Name: serial_mag_comp_ctrl

Overview:
Sequencer that compares two WIDTH-bit unsigned operands. It runs them through a single 2-bit magnitude-compare slice, one 2-bit digit per clock, MSB digit first. It captures the operands on a start handshake, steps the digit index, and accumulates the decision. It reports equal, greater or less with a one-cycle done pulse. Wide compares therefore reuse one small comparator instead of a full-width tree.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2.
DIGITS, WIDTH/2, derived localparam giving the number of 2-bit digits; not overridable.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  operand A, captured on an accepted start.
b  input  WIDTH  operand B, captured on an accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse in DONE.
aeb  output  1  registered result: A == B.
agb  output  1  registered result: A > B.
alb  output  1  registered result: A < B.

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE.
  - busy, done, aeb, agb, alb all go to 0.
  - shift registers, digit index and decision flags are cleared.
  - Reset asserted mid-RUN aborts the operation; no done is issued.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge k: capture a and b into shift registers, set idx=DIGITS-1, clear the decision flags, go to RUN.
- RUN (busy=1):
  - Each cycle, compare the top 2 bits of the A shift register against the top 2 bits of the B shift register using the 2-bit slice (eq/gt/lt).
  - If the digit differs and no decision is recorded yet, record gt or lt.
  - Shift both registers left by 2 and decrement idx.
  - Exit to DONE when idx==0 has been processed (or early; see Optional Feature).
- Result registers:
  - aeb/agb/alb update on the edge entering DONE.
  - No decision recorded gives aeb=1; otherwise agb or alb per the recorded decision.
  - Exactly one of the three is high after any completion.
  - They hold until the next completion or reset.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Always returns to IDLE on the next edge.
  - start is ignored in DONE and RUN; there is no queuing.
- Latency:
  - start sampled at edge k, RUN occupies cycles k+1..k+m, done is high in cycle k+m+1.
  - m=DIGITS without early exit.
  - Back-to-back: start held high re-accepts in the IDLE cycle after DONE, giving a throughput of one compare per m+2 cycles.
- Operands a and b may change freely after capture; the result reflects the captured values only.
- DIGITS=1: a single RUN cycle.

Optional Feature:
Macro EARLY_EXIT_EN.
- Defined: RUN exits to DONE in the cycle the first differing digit is found, so m equals the 1-based position of the first differing digit counted from the MSB, or DIGITS if all digits are equal.
- Undefined: constant-time operation. RUN always lasts DIGITS cycles; the first difference is latched in a sticky flag and later digits are ignored.
- Result values are identical in both builds; only done timing differs.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, start pulse at edge 0 -> busy during cycles 1-4, done in cycle 5, aeb=1 agb=0 alb=0 (both builds).
- a=0x80, b=0x40 -> agb=1; done in cycle 2 with EARLY_EXIT_EN, cycle 5 without.
- a=0x12, b=0x13 -> alb=1, done in cycle 5 in both builds (last digit differs); a=0x00, b=0xFF -> alb=1.
- start held high for 20 cycles with fixed operands -> done pulses spaced m+2 cycles apart, busy never high during DONE, results stable.
- Capture a=0x30, b=0x20, then drive a=0x00 in cycle 1 -> agb=1 (captured value used); start asserted during RUN is ignored, with no extra done.
- rst_n driven low asynchronously mid-RUN (cycle 2) -> busy, done, aeb, agb, alb are 0 immediately; after release, IDLE and a new start completes normally.
